// File: rtl/lp_filter_mux_signed_pkg.sv
// Shared constants and width helpers for the time-multiplexed lowpass filter.
package lp_filter_mux_signed_pkg;

    // Deepest cascade the filter is built for.
    localparam int MAX_STAGE_COUNT = 5;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Channel tag width; a single-channel build still carries one tag bit.
    function automatic int ch_bits(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

    // Accumulator width: output width plus the fractional bits of the shift.
    function automatic int calc_w(input int out_bits, input int shift_bits);
        return out_bits + shift_bits;
    endfunction

endpackage

// File: rtl/lp_filter_mux_stage.sv
// One pipeline step of the multiplexed filter: per-channel accumulator file,
// update/preload arithmetic and the registers that pass the sample on.
module lp_filter_mux_stage
    import lp_filter_mux_signed_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int CH_BITS       = 2,
    parameter int OUT_DATA_BITS = 28,
    parameter int SHIFT_BITS    = 5
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_ce,
    input  logic                            i_valid,
    input  logic [CH_BITS-1:0]              i_channel,
    input  logic                            i_preload,
    input  logic signed [OUT_DATA_BITS-1:0] i_value,
    output logic                            o_valid,
    output logic [CH_BITS-1:0]              o_channel,
    output logic                            o_preload,
    output logic signed [OUT_DATA_BITS-1:0] o_value
);

    localparam int W = calc_w(OUT_DATA_BITS, SHIFT_BITS);

    logic signed [W-1:0]             r_acc [0:CHANNELS-1];
    logic signed [W-1:0]             w_acc_rd;
    logic signed [W-1:0]             w_x_ext;
    logic signed [W-1:0]             w_acc_nxt;
    logic signed [OUT_DATA_BITS-1:0] w_x_nxt;

    // Select the accumulator of the incoming sample's channel.
    always_comb begin
        w_acc_rd = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_channel == CH_BITS'(c)) begin
                w_acc_rd = r_acc[c];
            end
        end
    end

    assign w_x_ext = W'(i_value);

    // Next accumulator value and the value handed to the next stage.
    // NOTE: both branches assign every output of this block, so no latch is inferred.
    always_comb begin
        if (i_preload) begin
            w_acc_nxt = w_x_ext <<< SHIFT_BITS;
            w_x_nxt   = i_value;
        end else begin
            w_acc_nxt = w_acc_rd + w_x_ext - (w_acc_rd >>> SHIFT_BITS);
            w_x_nxt   = w_acc_nxt[W-1:SHIFT_BITS];
        end
    end

    // Write back the accumulator of the accepted sample's channel.
    // NOTE: the accumulator file is reset explicitly because every channel must
    // start filtering from zero; it is small, so this costs nothing meaningful.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
            end
        end else if (i_ce && i_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (i_channel == CH_BITS'(c)) begin
                    r_acc[c] <= w_acc_nxt;
                end
            end
        end
    end

    // Carry the sample tag and stage result one step down the pipeline.
    // NOTE: non-blocking assignments so all stages sample their inputs before any updates.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid   <= 1'b0;
            o_channel <= '0;
            o_preload <= 1'b0;
            o_value   <= '0;
        end else if (i_ce) begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_channel <= i_channel;
                o_preload <= i_preload;
                o_value   <= w_x_nxt;
            end
        end
    end

endmodule

// File: rtl/lp_filter_mux_signed.sv
// Multi-channel signed lowpass filter: aligns incoming samples, drops samples
// for channels that do not exist and runs them through a chain of stages.
module lp_filter_mux_signed
    import lp_filter_mux_signed_pkg::*;
#(
    parameter int  CHANNELS      = 4,
    parameter int  IN_DATA_BITS  = 28,
    parameter int  OUT_DATA_BITS = 28,
    parameter int  SHIFT_BITS    = 5,
    parameter int  STAGE_COUNT   = 2,
    localparam int CH_BITS       = ch_bits(CHANNELS)
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_ce,
    input  logic                            i_in_valid,
    input  logic [CH_BITS-1:0]              i_in_channel,
    input  logic                            i_in_preload,
    input  logic signed [IN_DATA_BITS-1:0]  i_in_value,
    output logic                            o_out_valid,
    output logic [CH_BITS-1:0]              o_out_channel,
    output logic signed [OUT_DATA_BITS-1:0] o_out_value
);

    logic                            w_ch_ok;
    logic signed [OUT_DATA_BITS-1:0] w_x0;

    logic                            w_stage_valid   [0:STAGE_COUNT];
    logic [CH_BITS-1:0]              w_stage_channel [0:STAGE_COUNT];
    logic                            w_stage_preload [0:STAGE_COUNT];
    logic signed [OUT_DATA_BITS-1:0] w_stage_value   [0:STAGE_COUNT];

    // Flag samples whose channel tag addresses an existing channel.
    always_comb begin
        w_ch_ok = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_in_channel == CH_BITS'(c)) begin
                w_ch_ok = 1'b1;
            end
        end
    end

    // Left-align the sample to the output width; the low bits become zero.
    assign w_x0 = OUT_DATA_BITS'(i_in_value) <<< (OUT_DATA_BITS - IN_DATA_BITS);

    assign w_stage_valid[0]   = i_in_valid && w_ch_ok;
    assign w_stage_channel[0] = i_in_channel;
    assign w_stage_preload[0] = i_in_preload;
    assign w_stage_value[0]   = w_x0;

    for (genvar k = 0; k < STAGE_COUNT; k++) begin : g_stage
        lp_filter_mux_stage #(
            .CHANNELS      (CHANNELS),
            .CH_BITS       (CH_BITS),
            .OUT_DATA_BITS (OUT_DATA_BITS),
            .SHIFT_BITS    (SHIFT_BITS)
        ) u_stage (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_ce      (i_ce),
            .i_valid   (w_stage_valid[k]),
            .i_channel (w_stage_channel[k]),
            .i_preload (w_stage_preload[k]),
            .i_value   (w_stage_value[k]),
            .o_valid   (w_stage_valid[k+1]),
            .o_channel (w_stage_channel[k+1]),
            .o_preload (w_stage_preload[k+1]),
            .o_value   (w_stage_value[k+1])
        );
    end

    assign o_out_valid   = w_stage_valid[STAGE_COUNT];
    assign o_out_channel = w_stage_channel[STAGE_COUNT];
    assign o_out_value   = w_stage_value[STAGE_COUNT];

endmodule
